carry_normalize: RTL
====================

# carry_normalize

Post-processing stage directly downstream of the FFT multiplier core in the 1024-bit large-multiplication datapath. It consumes the stream of integer convolution coefficients produced by the inverse transform, least-significant digit first. It propagates carries digit by digit and assembles the final 2048-bit binary product. It flags any carry left over after the last digit as overflow.

## Interface

Parameters:
- DIGIT_W, 8, bits per digit (radix 2^DIGIT_W).
- NUM_DIGITS, 256, coefficients per product (2*1024/DIGIT_W).
- COEF_W, 24, width of each unsigned convolution coefficient.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new product. Sampled only in IDLE.
- coef_in  input  COEF_W  unsigned coefficient, digit index k in arrival order k = 0..NUM_DIGITS-1.
- coef_valid  input  1  coef_in is valid this cycle.
- coef_ready  output  1  block accepts coef_in this cycle.
- product_out  output  DIGIT_W*NUM_DIGITS  assembled product; digit k at bits [k*DIGIT_W +: DIGIT_W].
- product_valid  output  1  level; product_out is complete and stable.
- done  output  1  one-cycle pulse when the product completes.
- busy  output  1  high from the cycle after an accepted start until done.
- overflow  output  1  carry was nonzero after the last digit; valid with product_valid.

## Operation

- FSM states: IDLE, ACCUM, DONE.
- IDLE, start=1 sets the following, then moves to ACCUM:
  - idx=0, carry=0, product_out=0
  - product_valid=0, overflow=0
- IDLE, start=0: holds state; all outputs keep their values, so the last product remains readable.
- ACCUM: coef_ready=1. A transfer occurs when coef_valid && coef_ready. On each transfer:
  - sum = coef_in + carry, computed COEF_W+1 bits wide.
  - product digit idx <= sum[DIGIT_W-1:0].
  - carry <= sum >> DIGIT_W. This is bounded below 2^COEF_W, so the carry register is COEF_W bits.
  - idx <= idx+1.
- ACCUM, coef_valid=0: no change. Gaps of any length are legal.
- The transfer at idx = NUM_DIGITS-1 moves the FSM to DONE. Overflow is set from the carry computed in that same transfer (new carry != 0).
- DONE, held for one cycle: done=1, product_valid=1. Then the FSM moves to IDLE, and product_valid stays 1.
- start while busy (ACCUM/DONE) is ignored; it is not queued.
- coef_valid outside ACCUM is ignored, and coef_ready=0 there.

## Timing

- Reset values: state=IDLE, coef_ready=0, product_out=0, product_valid=0, done=0, busy=0, overflow=0, carry=0, idx=0.
- Reset asserted mid-product aborts immediately. The next edge yields the reset values, and the partial product is discarded.
- start accepted at edge T: busy=1 and coef_ready=1 from T+1.
- Throughput: one coefficient per cycle. Minimum latency from start to done is NUM_DIGITS+1 cycles; done rises the cycle after the last transfer.
- done, product_valid and overflow change on the same edge.
- busy falls on the edge where DONE exits to IDLE. A start in the first IDLE cycle after DONE is accepted, so back-to-back products need NUM_DIGITS+2 cycles each.
- Digit k of product_out is written at its transfer edge. Consumers use it only while product_valid=1.

## Test plan

- Reset, then idle: all outputs 0, coef_ready=0. start with all 256 coefficients = 0 -> done after 257 cycles, product_out=0, overflow=0.
- Single coefficient: coef[0]=0x1FF, rest 0. Result: digit0=0xFF, digit1=0x01, everything else 0, overflow=0.
- Carry ripple: coef[0]=0x100, coef[1..254]=0xFF, coef[255]=0. Result: digits 0..254 = 0x00, digit255=0x01, overflow=0.
- Real product: feed the convolution of (2^1024-1)^2 computed by the bench model. Result: product_out = 2^2048 - 2^1025 + 1. Repeat with random valid gaps (coef_valid low ~30%); the result must be identical, with done exactly once.
- Overflow: coef[255]=0x1FF, rest 0. Result: digit255=0xFF, overflow=1.
- Control robustness:
  - start pulsed mid-ACCUM is ignored; the result is unchanged.
  - rst_n low at idx=100 returns everything to reset values; a fresh start then gives the correct result.
  - start in the cycle after done is accepted.

Source files
------------

// File: rtl/carry_normalize.sv
// Carry-propagation stage behind the FFT multiplier: turns LSD-first convolution
// coefficients into a packed binary product, flagging any carry out of the top digit.
module carry_normalize #(
  parameter int unsigned DIGIT_W    = 8,
  parameter int unsigned NUM_DIGITS = 256,
  parameter int unsigned COEF_W     = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [COEF_W-1:0]             coef_in,
  input  logic                          coef_valid,
  output logic                          coef_ready,
  output logic [DIGIT_W*NUM_DIGITS-1:0] product_out,
  output logic                          product_valid,
  output logic                          done,
  output logic                          busy,
  output logic                          overflow
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SUM_W  = COEF_W + 1;
  localparam int unsigned PROD_W = DIGIT_W * NUM_DIGITS;
  localparam int unsigned OFF_W  = (PROD_W > 1) ? $clog2(PROD_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_d;
  logic [COEF_W-1:0]   carry_q;
  logic [COEF_W-1:0]   carry_d;
  logic                ready_d;
  logic                busy_d;
  logic                done_d;
  logic                valid_d;
  logic                ovf_d;
  logic                clear_c;
  logic                xfer_c;
  logic                last_c;
  logic [SUM_W-1:0]    sum_c;
  logic [COEF_W-1:0]   carry_new_c;
  logic [OFF_W-1:0]    off_c;

  // Datapath: one coefficient plus the running carry per transfer.
  assign xfer_c      = (state_q == S_ACCUM) && coef_valid;
  assign last_c      = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign sum_c       = SUM_W'(coef_in) + SUM_W'(carry_q);
  assign carry_new_c = COEF_W'(sum_c >> DIGIT_W);
  assign off_c       = OFF_W'(idx_q) * OFF_W'(DIGIT_W);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (xfer_c && last_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; flags are derived from the next state so they
  // line up with the state they describe.
  always_comb begin
    ready_d = (state_d == S_ACCUM);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    valid_d = product_valid;
    ovf_d   = overflow;
    idx_d   = idx_q;
    carry_d = carry_q;
    clear_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear_c = 1'b1;
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          carry_d = '0;
        end
      end
      S_ACCUM: begin
        if (xfer_c) begin
          idx_d   = idx_q + IDX_W'(1);
          carry_d = carry_new_c;
          if (last_c) begin
            valid_d = 1'b1;
            ovf_d   = (carry_new_c != '0);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coef_ready    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      product_valid <= 1'b0;
      overflow      <= 1'b0;
      idx_q         <= '0;
      carry_q       <= '0;
      product_out   <= '0;
    end else begin
      coef_ready    <= ready_d;
      busy          <= busy_d;
      done          <= done_d;
      product_valid <= valid_d;
      overflow      <= ovf_d;
      idx_q         <= idx_d;
      carry_q       <= carry_d;
      if (clear_c) begin
        product_out <= '0;
      end else if (xfer_c) begin
        product_out[off_c +: DIGIT_W] <= sum_c[DIGIT_W-1:0];
      end
    end
  end

endmodule
